// File: rtl/mem_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator_pkg
// Description : Shared types and widths for the register-file memory initiator.
// Revision    : 1.0
// ============================================================================
package mem_initiator_pkg;

    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 8;
    localparam int HOLD_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Drives the 8x8 register-file memory pins for single read/write
//               requests, holding R or W for HOLD_CYCLES and returning reads.
// Revision    : 1.0
// ============================================================================
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic              adr0,
    output logic              adr1,
    output logic              adr2,
    output logic              i0,
    output logic              i1,
    output logic              i2,
    output logic              i3,
    output logic              i4,
    output logic              i5,
    output logic              i6,
    output logic              i7,
    output logic              R,
    output logic              W,
    input  logic              o0,
    input  logic              o1,
    input  logic              o2,
    input  logic              o3,
    input  logic              o4,
    input  logic              o5,
    input  logic              o6,
    input  logic              o7
);

    localparam logic [HOLD_CNT_W-1:0] c_hold_load = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] c_cnt_one   = HOLD_CNT_W'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [HOLD_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [ADDR_W-1:0]     r_adr;
    logic [DATA_W-1:0]     r_i;
    logic                  r_r;
    logic                  r_w;
    logic                  r_wr_done;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;

    logic                  w_accept;
    logic                  w_cnt_zero;
    logic [DATA_W-1:0]     w_o;
    logic [ADDR_W-1:0]     w_adr_d;
    logic [DATA_W-1:0]     w_i_d;
    logic                  w_r_d;
    logic                  w_w_d;
    logic                  w_wr_done_d;

    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_o        = {o7, o6, o5, o4, o3, o2, o1, o0};

    // State and all memory-side pins are registered together
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_adr     <= '0;
            r_i       <= '0;
            r_r       <= 1'b0;
            r_w       <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_adr     <= w_adr_d;
            r_i       <= w_i_d;
            r_r       <= w_r_d;
            r_w       <= w_w_d;
            r_wr_done <= w_wr_done_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = req_write ? WRITE : READ;
            WRITE:   if (w_cnt_zero) w_next_state = IDLE;
            READ:    if (w_cnt_zero) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Pin values for the cycle after the edge follow the state being entered
    always_comb begin
        w_adr_d     = '0;
        w_i_d       = '0;
        w_r_d       = 1'b0;
        w_w_d       = 1'b0;
        w_wr_done_d = (r_state == WRITE) && w_cnt_zero;
        case (w_next_state)
            WRITE: begin
                w_w_d   = 1'b1;
                w_adr_d = w_accept ? req_addr : r_addr;
                w_i_d   = w_accept ? req_wdata : r_wdata;
            end
            READ: begin
                w_r_d   = 1'b1;
                w_adr_d = w_accept ? req_addr : r_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_hold_load;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (((r_state == WRITE) || (r_state == READ)) && !w_cnt_zero) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            if ((r_state == READ) && w_cnt_zero) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_o;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign wr_done   = r_wr_done;
    assign R         = r_r;
    assign W         = r_w;
    assign adr0      = r_adr[0];
    assign adr1      = r_adr[1];
    assign adr2      = r_adr[2];
    assign i0        = r_i[0];
    assign i1        = r_i[1];
    assign i2        = r_i[2];
    assign i3        = r_i[3];
    assign i4        = r_i[4];
    assign i5        = r_i[5];
    assign i6        = r_i[6];
    assign i7        = r_i[7];

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Bench for mem_initiator; instance 0 uses HOLD_CYCLES=2, instance 1
//               uses HOLD_CYCLES=1, each wired to a behavioural register-file memory.
// Revision    : 1.0
// ============================================================================
module tb_mem_initiator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_write, rsp_ready;
    logic [1:0][2:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0][7:0] o_v;
    wire  [1:0]      req_ready_w, rsp_valid_w, wr_done_w, r_w, w_w;
    wire  [1:0][7:0] rsp_rdata_w, i_w;
    wire  [1:0][2:0] adr_w;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_initiator #(.HOLD_CYCLES(g == 0 ? 2 : 1)) u_dut (
            .CLK(clk), .RST_N(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready_w[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid_w[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata_w[g]),
            .wr_done(wr_done_w[g]),
            .adr0(adr_w[g][0]), .adr1(adr_w[g][1]), .adr2(adr_w[g][2]),
            .i0(i_w[g][0]), .i1(i_w[g][1]), .i2(i_w[g][2]), .i3(i_w[g][3]),
            .i4(i_w[g][4]), .i5(i_w[g][5]), .i6(i_w[g][6]), .i7(i_w[g][7]),
            .R(r_w[g]), .W(w_w[g]),
            .o0(o_v[g][0]), .o1(o_v[g][1]), .o2(o_v[g][2]), .o3(o_v[g][3]),
            .o4(o_v[g][4]), .o5(o_v[g][5]), .o6(o_v[g][6]), .o7(o_v[g][7])
        );
    end

    int checks = 0;
    int errors = 0;

    function automatic int hold_of(int n);
        return (n == 0) ? 2 : 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file memory: a write commits only once W has been held the full window
    logic [7:0] mem [2][8];
    int         mcnt [2] = '{0, 0};
    logic [2:0] madr [2];
    logic [7:0] mdat [2];

    always_comb begin
        for (int n = 0; n < 2; n++) o_v[n] = r_w[n] ? mem[n][adr_w[n]] : 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                mcnt[n] = 0;
            end else if (w_w[n]) begin
                mcnt[n]++;
                madr[n] = adr_w[n];
                mdat[n] = i_w[n];
            end else begin
                if (mcnt[n] >= hold_of(n)) mem[n][madr[n]] = mdat[n];
                mcnt[n] = 0;
            end
        end
    end

    // Transaction-level model: acceptance edge, completion edge, pending response
    int         edge_n = 0;
    int         m_acc [2] = '{-1, -1};
    bit         m_wr [2];
    logic [2:0] m_addr [2];
    logic [7:0] m_data [2];
    bit         m_pend [2];
    logic [7:0] m_rdata [2];
    int         m_done [2] = '{-1, -1};
    logic [7:0] shadow [2][8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                m_acc[n] = -1; m_pend[n] = 1'b0; m_rdata[n] = 8'h00; m_done[n] = -1;
            end
        end else begin
            edge_n++;
            for (int n = 0; n < 2; n++) begin
                bit was_idle, was_pend;
                was_idle = (m_acc[n] < 0) && !m_pend[n];
                was_pend = m_pend[n];
                if (m_acc[n] >= 0 && edge_n == m_acc[n] + hold_of(n)) begin
                    if (m_wr[n]) begin
                        shadow[n][m_addr[n]] = m_data[n];
                        m_done[n] = edge_n;
                    end else begin
                        m_pend[n]  = 1'b1;
                        m_rdata[n] = shadow[n][m_addr[n]];
                    end
                    m_acc[n] = -1;
                end else if (was_pend && rsp_ready[n]) begin
                    m_pend[n] = 1'b0;
                end
                if (was_idle && req_valid[n]) begin
                    m_acc[n]  = edge_n;
                    m_wr[n]   = req_write[n];
                    m_addr[n] = req_addr[n];
                    m_data[n] = req_wdata[n];
                end
            end
        end
    end

    // Per-cycle compare of every output against the model, plus pin monitors
    bit   w_prev [2] = '{1'b0, 1'b0};
    int   done_cnt [2] = '{0, 0};
    int   rise1 [$];

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            bit act;
            logic [23:0] got, exp;
            act = (m_acc[n] >= 0);
            exp = {!act && !m_pend[n], m_pend[n], m_rdata[n], m_done[n] == edge_n,
                   act && !m_wr[n], act && m_wr[n], act ? m_addr[n] : 3'd0,
                   (act && m_wr[n]) ? m_data[n] : 8'h00};
            got = {req_ready_w[n], rsp_valid_w[n], rsp_rdata_w[n], wr_done_w[n],
                   r_w[n], w_w[n], adr_w[n], i_w[n]};
            chk($sformatf("model[%0d]", n), 32'(got), 32'(exp));
            chk($sformatf("r_and_w[%0d]", n), 32'(r_w[n] & w_w[n]), 32'd0);
            if (wr_done_w[n]) done_cnt[n]++;
            if (n == 1 && w_w[n] && !w_prev[n]) rise1.push_back(edge_n);
            w_prev[n] = w_w[n];
        end
    end

    task automatic issue(int n, bit wr, logic [2:0] a, logic [7:0] d, bit keep);
        int t = 0;
        req_valid[n] = 1'b1; req_write[n] = wr; req_addr[n] = a; req_wdata[n] = d;
        while (!req_ready_w[n] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        if (!keep) req_valid[n] = 1'b0;
    endtask

    task automatic wait_rsp(int n);
        int t = 0;
        while (!rsp_valid_w[n] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_write(int n, logic [2:0] a, logic [7:0] d, output int width);
        issue(n, 1'b1, a, d, 1'b0);
        width = 0;
        while (w_w[n] && width < 50) begin
            width++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(int n, logic [2:0] a, output logic [7:0] rd);
        issue(n, 1'b0, a, 8'h00, 1'b0);
        wait_rsp(n);
        rd = rsp_rdata_w[n];
        rsp_ready[n] = 1'b1;
        @(negedge clk);
        rsp_ready[n] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         wd;
        logic [7:0] rd;
        req_valid = '0; req_write = '0; rsp_ready = '0; req_addr = '0; req_wdata = '0;
        for (int n = 0; n < 2; n++)
            for (int a = 0; a < 8; a++) begin
                mem[n][a]    = 8'(a * 17 + n);
                shadow[n][a] = 8'(a * 17 + n);
            end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({r_w[0], w_w[0], adr_w[0], i_w[0], rsp_valid_w[0], wr_done_w[0]}), 32'd0);
        chk("reset_rdata", 32'(rsp_rdata_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic writes then readback
        do_write(0, 3'd0, 8'd73, wd);
        chk("w_width_a0", 32'(wd), 32'd2);
        do_write(0, 3'd1, 8'd97, wd);
        chk("w_width_a1", 32'(wd), 32'd2);
        do_read(0, 3'd0, rd);
        chk("rd_a0", 32'(rd), 32'd73);
        do_read(0, 3'd1, rd);
        chk("rd_a1", 32'(rd), 32'd97);

        // Response back-pressure
        issue(0, 1'b0, 3'd1, 8'h00, 1'b0);
        wait_rsp(0);
        repeat (5) begin
            chk("bp_hold", 32'({rsp_valid_w[0], rsp_rdata_w[0], req_ready_w[0], r_w[0]}),
                32'({1'b1, 8'd97, 1'b0, 1'b0}));
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("bp_release", 32'({rsp_valid_w[0], req_ready_w[0]}), 32'b01);

        // Write held pending while a read is in flight
        issue(0, 1'b0, 3'd0, 8'h00, 1'b0);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 3'd2; req_wdata[0] = 8'h5A;
        wait_rsp(0);
        repeat (2) begin
            chk("pend_no_w", 32'(w_w[0]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("pend_rd", 32'(rsp_rdata_w[0]), 32'd73);
        chk("pend_gap", 32'({w_w[0], req_ready_w[0]}), 32'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("pend_w_rise", 32'({w_w[0], adr_w[0], i_w[0]}), 32'({1'b1, 3'd2, 8'h5A}));
        repeat (3) @(negedge clk);

        // Reset in the middle of a write window
        issue(0, 1'b1, 3'd0, 8'h3C, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_pins", 32'({w_w[0], adr_w[0], i_w[0]}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_w[0]), 32'd1);
        do_read(0, 3'd0, rd);
        chk("rst_prior", 32'(rd), 32'd73);
        do_read(0, 3'd2, rd);
        chk("rd_a2", 32'(rd), 32'h5A);

        // HOLD_CYCLES=1 back-to-back writes
        issue(1, 1'b1, 3'd7, 8'hFF, 1'b1);
        issue(1, 1'b1, 3'd6, 8'h00, 1'b1);
        issue(1, 1'b1, 3'd5, 8'hA5, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b_pulses", 32'(rise1.size()), 32'd3);
        if (rise1.size() == 3) begin
            chk("b2b_gap1", 32'(rise1[1] - rise1[0]), 32'd2);
            chk("b2b_gap2", 32'(rise1[2] - rise1[1]), 32'd2);
        end
        do_read(1, 3'd7, rd);
        chk("h1_rd7", 32'(rd), 32'hFF);
        do_read(1, 3'd6, rd);
        chk("h1_rd6", 32'(rd), 32'h00);
        do_read(1, 3'd5, rd);
        chk("h1_rd5", 32'(rd), 32'hA5);

        // rsp_ready with nothing pending is ignored
        rsp_ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready[1] = 1'b0;
        chk("idle_rsp_ready", 32'({req_ready_w[1], rsp_valid_w[1]}), 32'b10);

        repeat (2) @(negedge clk);
        chk("wr_done_cnt0", 32'(done_cnt[0]), 32'd3);
        chk("wr_done_cnt1", 32'(done_cnt[1]), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Host-side initiator for the 8x8 register-file memory FSM; it is the opposite end of the memory's R/W/address/data pin interface. It accepts single read or write requests over a valid/ready port and drives adr0..adr2, i0..i7, R and W for a fixed hold window. On reads it captures o0..o7 and returns the data over a valid/ready response port. Its pin outputs connect one-to-one to the memory FSM's pins, replacing hand-driven bench stimulus.

Parameters:
HOLD_CYCLES, 2, clock cycles that R or W plus address/data are held per command (legal range 1..15).
ADDR_W, 3, address width; fixed by the memory pinout.
DATA_W, 8, data width; fixed by the memory pinout.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
req_valid  input  1  request offered.
req_ready  output  1  initiator can accept a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  3  target address.
req_wdata  input  8  write data (ignored on reads).
rsp_valid  output  1  read data available.
rsp_ready  input  1  consumer takes read data.
rsp_rdata  output  8  captured read data.
wr_done  output  1  one-cycle pulse when a write window completes.
adr0, adr1, adr2  output  1 each  memory address bits (LSB first).
i0..i7  output  1 each  memory write-data bits (LSB first).
R  output  1  memory read strobe.
W  output  1  memory write strobe.
o0..o7  input  1 each  memory read-data bits (LSB first).

Behaviour:
- Reset (async, RST_N=0): state=IDLE, hold counter=0; R=W=0; adr*=0; i*=0; rsp_valid=0; rsp_rdata=0; wr_done=0. Release is synchronous to the next CLK edge.
- All memory-side outputs are registered; R and W are never 1 together.
- States: IDLE, WRITE, READ, RESP. req_ready = (state==IDLE), with no combinational path from req_valid.
- IDLE: R=W=0; adr and i driven 0. On an edge with req_valid&req_ready, latch addr, wdata and write; load counter=HOLD_CYCLES-1; go to WRITE or READ.
- WRITE: W=1; adr=latched addr; i=latched wdata. At the edge where counter==0, go to IDLE, pulse wr_done for the following cycle, and clear W/adr/i on that same edge. Otherwise decrement the counter.
- READ: R=1; adr=latched addr; i=0. At the edge where counter==0, sample o0..o7 into rsp_rdata, set rsp_valid=1, clear R/adr, and go to RESP.
- RESP: R=W=0; rsp_valid and rsp_rdata held stable. On an edge with rsp_ready=1, clear rsp_valid and go to IDLE. rsp_rdata keeps its last value.
- Timing: if a request is accepted at edge k, the strobe is high from k to k+HOLD_CYCLES. Read data is sampled at edge k+HOLD_CYCLES, and rsp_valid is high immediately after it. The earliest next acceptance is edge k+HOLD_CYCLES (write) or the rsp_ready edge (read).
- HOLD_CYCLES=1: strobe lasts exactly one cycle. Back-to-back writes accept every 2 cycles with one idle gap cycle (W=0).
- Requests offered while busy are not accepted; the requester must hold req_valid and its fields stable until accepted.
- A request change after acceptance does not affect the command in flight.
- Reset mid-command: R/W drop immediately (async), the command is abandoned, and no response or wr_done is produced.
- rsp_ready high while no response is pending has no effect.

Decomposition:
- Package mem_initiator_pkg holds: state enum (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3), ADDR_W=3, DATA_W=8, HOLD_CNT_W=4.
- No sub-module is needed: a single FSM plus a 4-bit down-counter and capture registers. Bit-level pin fan-out is done with assigns in the top module.

Test Plan:
- Write addr 0 data 73 (0x49), then write addr 1 data 97 (0x61), then read addr 0 and read addr 1 against the memory FSM. Required: W high exactly 2 cycles per write; rsp_rdata=73, then 97.
- Read with rsp_ready=0 for 5 cycles. Required: rsp_valid stays 1, rsp_rdata stable, req_ready=0 throughout, no R pulse. After rsp_ready=1 for one edge: rsp_valid=0 and req_ready=1.
- Hold req_valid=1 with a write while a read is in flight. Required: the write is accepted only after the response handshake, and W rises the following cycle.
- Assert RST_N=0 mid-WRITE (after 1 of 2 hold cycles). Required: W=0 and adr/i=0 immediately; no wr_done; req_ready=1 after release. A subsequent read of that address returns the prior contents.
- With HOLD_CYCLES=1, issue back-to-back writes to addresses 7, 6, 5 (data 0xFF, 0x00, 0xA5). Required: each W pulse is 1 cycle and the pulses are spaced 2 cycles apart. Readback returns 0xFF, 0x00, 0xA5.
- Monitor R and W for the entire run of every scenario. Required: R&W never both 1, and wr_done pulses exactly once per completed write.
